// File: rtl/mips_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Contents:
//   MEM_ADDR_W / MEM_DATA_W : default byte-address and word widths
//   arb_state_e             : arbiter FSM states (IDLE, D_BUSY, I_BUSY)
package mips_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the fetch stage and the
// MEM stage of a stalling pipeline. At most one access per requester is
// performed per pipeline cycle; the data access (older instruction) goes
// first, the fetch second, and the pipeline is stalled until every active
// requester of the current pipeline cycle has been served.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   i_req, i_addr, i_rdata      : fetch request, PC, registered instruction
//   memtoreg, memwrite          : MEM-stage load / store
//   aluout, writedata, d_rdata  : data address, store data, registered load data
//   stall                       : combinational pipeline freeze
//   mem_req, mem_we, mem_addr,
//   mem_wdata                   : registered memory request
//   mem_rdata, mem_ready        : memory response
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              memtoreg,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] aluout,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_e        state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              i_served_q,  i_served_d;
    logic              d_served_q,  d_served_d;
    logic              d_req_s;
    logic              stall_s;

    // Request decode and pipeline stall: a requester still needing its
    // access for this pipeline cycle holds the whole pipeline.
    always_comb begin
        d_req_s = memtoreg | memwrite;
        stall_s = (d_req_s & ~d_served_q) | (i_req & ~i_served_q);
    end

    // Next-state logic for the FSM, memory request and captured data.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_served_d  = i_served_q;
        d_served_d  = d_served_q;

        case (state_q)
            IDLE: begin
                // Issue conditions imply stall=1, so nothing is issued on
                // an advancing cycle. mem_ready is ignored here.
                if (d_req_s && !d_served_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = memwrite;
                    mem_addr_d  = aluout;
                    mem_wdata_d = writedata;
                    state_d     = D_BUSY;
                end else if (i_req && !i_served_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_addr;
                    state_d    = I_BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            D_BUSY: begin
                // Latched request stays on the bus until completion; the
                // live inputs are not looked at again.
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                    d_served_d = 1'b1;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    state_d    = IDLE;
                end else begin
                    state_d = D_BUSY;
                end
            end
            I_BUSY: begin
                if (mem_ready) begin
                    i_rdata_d  = mem_rdata;
                    i_served_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end else begin
                    state_d = I_BUSY;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        // An advancing pipeline starts a fresh pipeline cycle. This wins
        // over a completion that lands on the same edge (request withdrawn
        // while busy), so the next instruction is never marked as served.
        if (!stall_s) begin
            i_served_d = 1'b0;
            d_served_d = 1'b0;
        end else begin
            i_served_d = i_served_d;
            d_served_d = d_served_d;
        end
    end

    // State registers with synchronous reset; reset abandons any access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            i_rdata_q   <= {DATA_W{1'b0}};
            d_rdata_q   <= {DATA_W{1'b0}};
            i_served_q  <= 1'b0;
            d_served_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_served_q  <= i_served_d;
            d_served_q  <= d_served_d;
        end
    end

    assign stall     = stall_s;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_rdata;
    logic        memtoreg = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] aluout = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] d_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } acc_t;

    // Behavioural memory: word store, access log, latency schedule.
    logic [31:0] mem_m [logic [31:0]];
    acc_t        acc_log [$];
    int          lat_q [$];
    bit          auto_mem = 1'b1;
    bit          mb_busy = 1'b0;
    int          mb_cnt = 0;
    acc_t        mb_cur;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .memtoreg(memtoreg), .memwrite(memwrite), .aluout(aluout),
        .writedata(writedata), .d_rdata(d_rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory responder: mem_ready arrives `lat` cycles into an access
    // (lat=1 -> in the first cycle mem_req is high).
    task automatic mem_tick();
        if (auto_mem) begin
            if (mem_ready) begin
                mem_ready = 1'b0;
                mb_busy   = 1'b0;
            end
            if (mem_req === 1'b1 && !mb_busy) begin
                mb_busy = 1'b1;
                mb_cur  = '{mem_addr, mem_we, mem_wdata};
                acc_log.push_back(mb_cur);
                mb_cnt  = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
            end
            if (mb_busy) begin
                mb_cnt = mb_cnt - 1;
                if (mb_cnt == 0) begin
                    mem_ready = 1'b1;
                    if (mb_cur.we) begin
                        mem_m[mb_cur.addr] = mb_cur.wdata;
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = rd(mb_cur.addr);
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        mem_tick();
    endtask

    task automatic clear_inputs();
        i_req = 1'b0; memtoreg = 1'b0; memwrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (i_rdata !== 32'd0) begin errors++; $display("FAIL reset_i_rdata got=%h exp=0", i_rdata); end
        checks++; if (d_rdata !== 32'd0) begin errors++; $display("FAIL reset_d_rdata got=%h exp=0", d_rdata); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        reset = 1'b0;
    endtask

    task automatic test_fetch_only();
        mem_m[32'h0040_0000] = 32'h8C08_0004;
        lat_q.delete(); lat_q.push_back(1);
        i_req = 1'b1; i_addr = 32'h0040_0000;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0 got=%b exp=1", stall); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0000 || mem_we !== 1'b0)
            begin errors++; $display("FAIL fetch_issue got req=%b addr=%h we=%b exp 1 00400000 0", mem_req, mem_addr, mem_we); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_c1 got=%b exp=1", stall); end
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fetch_stall_c2 got=%b exp=0", stall); end
        checks++; if (i_rdata !== 32'h8C08_0004) begin errors++; $display("FAIL fetch_rdata got=%h exp=8c080004", i_rdata); end
        clear_inputs();
        step();
        acc_log.delete();
    endtask

    task automatic test_load_fetch();
        mem_m[32'h1001_0000] = 32'hCAFE_0001;
        mem_m[32'h0040_0004] = 32'h0085_1020;
        lat_q.delete(); lat_q.push_back(1); lat_q.push_back(1);
        memtoreg = 1'b1; aluout = 32'h1001_0000;
        i_req = 1'b1; i_addr = 32'h0040_0004;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lf_stall_c0 got=%b exp=1", stall); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1001_0000 || mem_we !== 1'b0)
            begin errors++; $display("FAIL lf_first_access got req=%b addr=%h we=%b exp 1 10010000 0", mem_req, mem_addr, mem_we); end
        step();
        checks++; if (stall !== 1'b1 || mem_req !== 1'b0)
            begin errors++; $display("FAIL lf_gap got stall=%b req=%b exp 1 0", stall, mem_req); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0004 || mem_we !== 1'b0 || stall !== 1'b1)
            begin errors++; $display("FAIL lf_second_access got req=%b addr=%h we=%b stall=%b exp 1 00400004 0 1", mem_req, mem_addr, mem_we, stall); end
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lf_stall_c4 got=%b exp=0", stall); end
        checks++; if (d_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL lf_d_rdata got=%h exp=cafe0001", d_rdata); end
        checks++; if (i_rdata !== 32'h0085_1020) begin errors++; $display("FAIL lf_i_rdata got=%h exp=00851020", i_rdata); end
        clear_inputs();
        step();
        acc_log.delete();
    endtask

    task automatic test_store();
        lat_q.delete(); lat_q.push_back(3);
        memwrite = 1'b1; aluout = 32'h1001_0008; writedata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 3; c++) begin
            step();
            writedata = $urandom;  // live inputs must not leak into the latched access
            aluout    = $urandom;
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h1001_0008 || stall !== 1'b1)
                begin errors++; $display("FAIL store_hold c%0d got req=%b we=%b wdata=%h addr=%h stall=%b exp 1 1 deadbeef 10010008 1", c, mem_req, mem_we, mem_wdata, mem_addr, stall); end
        end
        step();
        checks++; if (stall !== 1'b0 || mem_we !== 1'b0 || mem_req !== 1'b0)
            begin errors++; $display("FAIL store_done got stall=%b we=%b req=%b exp 0 0 0", stall, mem_we, mem_req); end
        checks++; if (d_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL store_d_rdata got=%h exp=cafe0001", d_rdata); end
        clear_inputs();
        step();
        acc_log.delete();
    endtask

    task automatic test_reset_busy();
        auto_mem = 1'b0;
        memtoreg = 1'b1; aluout = 32'h1001_0000;
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rb_issue got=%b exp=1", mem_req); end
        reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        reset = 1'b0; mem_ready = 1'b0; clear_inputs();
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'd0 || stall !== 1'b0)
            begin errors++; $display("FAIL rb_cleared got req=%b addr=%h stall=%b exp 0 0 0", mem_req, mem_addr, stall); end
        checks++; if (d_rdata !== 32'd0) begin errors++; $display("FAIL rb_d_rdata got=%h exp=0", d_rdata); end
        step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rb_idle got=%b exp=0", mem_req); end
    endtask

    task automatic test_stray_ready();
        auto_mem = 1'b0;
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'b1; mem_rdata = $urandom;
            step();
            checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || i_rdata !== 32'd0 || d_rdata !== 32'd0)
                begin errors++; $display("FAIL stray c%0d got stall=%b req=%b i=%h d=%h exp 0 0 0 0", c, stall, mem_req, i_rdata, d_rdata); end
        end
        mem_ready = 1'b0;
        mb_busy = 1'b0;
        auto_mem = 1'b1;
        step();
        acc_log.delete();
    endtask

    task automatic test_random();
        logic [31:0] exp_i = 32'd0;
        logic [31:0] exp_d = 32'd0;
        for (int n = 0; n < 40; n++) begin
            int   kind, cyc, exp_cyc, lat_d, lat_i;
            bit   ir;
            acc_t exp_acc [$];
            step();  // pipeline-advance edge for the previous instruction
            kind  = int'($urandom_range(0, 2));
            ir    = 1'($urandom_range(0, 1));
            lat_d = int'($urandom_range(1, 4));
            lat_i = int'($urandom_range(1, 4));
            aluout    = 32'h1001_0000 | (32'($urandom_range(0, 15)) << 2);
            i_addr    = 32'h0040_0000 | (32'($urandom_range(0, 255)) << 2);
            writedata = $urandom;
            memtoreg  = (kind == 1);
            memwrite  = (kind == 2);
            i_req     = ir;
            lat_q.delete();
            exp_cyc = 0;
            if (kind != 0) begin
                lat_q.push_back(lat_d);
                exp_cyc += 1 + lat_d;
                exp_acc.push_back('{aluout, (kind == 2), writedata});
                if (kind == 1) exp_d = rd(aluout);
            end
            if (ir) begin
                lat_q.push_back(lat_i);
                exp_cyc += 1 + lat_i;
                exp_acc.push_back('{i_addr, 1'b0, 32'd0});
                exp_i = rd(i_addr);
            end
            #1;
            cyc = 0;
            while (stall === 1'b1 && cyc < 100) begin
                step();
                cyc++;
            end
            checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL rnd%0d stall_cycles got=%0d exp=%0d", n, cyc, exp_cyc); end
            checks++; if (acc_log.size() !== exp_acc.size()) begin errors++; $display("FAIL rnd%0d access_count got=%0d exp=%0d", n, acc_log.size(), exp_acc.size()); end
            for (int k = 0; k < exp_acc.size() && k < acc_log.size(); k++) begin
                checks++;
                if (acc_log[k].addr !== exp_acc[k].addr || acc_log[k].we !== exp_acc[k].we ||
                    (exp_acc[k].we && acc_log[k].wdata !== exp_acc[k].wdata))
                    begin errors++; $display("FAIL rnd%0d access%0d got addr=%h we=%b wd=%h exp addr=%h we=%b wd=%h", n, k,
                        acc_log[k].addr, acc_log[k].we, acc_log[k].wdata, exp_acc[k].addr, exp_acc[k].we, exp_acc[k].wdata); end
            end
            checks++; if (d_rdata !== exp_d) begin errors++; $display("FAIL rnd%0d d_rdata got=%h exp=%h", n, d_rdata, exp_d); end
            checks++; if (i_rdata !== exp_i) begin errors++; $display("FAIL rnd%0d i_rdata got=%h exp=%h", n, i_rdata, exp_i); end
            acc_log.delete();
        end
        clear_inputs();
        step();
        checks++; if (acc_log.size() !== 0 || mem_req !== 1'b0)
            begin errors++; $display("FAIL rnd_quiet got accesses=%0d req=%b exp 0 0", acc_log.size(), mem_req); end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_load_fetch();
        test_store();
        test_reset_busy();
        test_stray_ready();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
